clkmgr_rst_seq: RTL and testbench

- Lock supervisor and staged reset sequencer that sits beside the board clock manager (DCM/MMCM instance).
- Runs on the free-running input reference clock. Drives the MMCM reset, qualifies LOCKED for stability, and releases NUM_CHAN downstream active-low domain resets in staggered order.
- Re-locks automatically after lock loss or lock timeout, with a bounded retry count, and reports status counters.

---
 rtl/clkmgr_pkg.sv | 28 ++
 rtl/clkmgr_rst_seq_if.sv | 29 ++
 rtl/clkmgr_sync2.sv | 20 ++
 rtl/clkmgr_rst_seq.sv | 206 ++++++++++++++++++++
 tb/tb_clkmgr_rst_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/clkmgr_pkg.sv
// Shared clock-manager definitions: sequencer state encodings and default timing.
package clkmgr_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_MRST    = 3'd0,
    S_WAIT    = 3'd1,
    S_STABLE  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  localparam int unsigned DEF_NUM_CHAN        = 4;
  localparam int unsigned DEF_STAGE_DELAY     = 16;
  localparam int unsigned DEF_LOCK_STABLE     = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 65536;
  localparam int unsigned DEF_MMCM_RST_CYCLES = 8;
  localparam int unsigned DEF_MAX_RETRY       = 0;
  localparam int unsigned DEF_CNT_WIDTH       = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkmgr_rst_seq_if.sv
// Lock input, soft restart and status outputs of the reset sequencer.
interface clkmgr_rst_seq_if
  import clkmgr_pkg::*;
#(
  parameter int unsigned NUM_CHAN  = DEF_NUM_CHAN,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);
  logic                 LOCKED_IN;
  logic                 SOFT_RST;
  logic                 MMCM_RST;
  logic [NUM_CHAN-1:0]  RST_N_OUT;
  logic                 READY;
  logic                 FAIL;
  logic [CNT_WIDTH-1:0] LOCK_LOSS_CNT;
  logic [CNT_WIDTH-1:0] RETRY_CNT;
  logic [STATE_W-1:0]   STATE;

  // Sequencer side.
  modport master (
    input  LOCKED_IN, SOFT_RST,
    output MMCM_RST, RST_N_OUT, READY, FAIL, LOCK_LOSS_CNT, RETRY_CNT, STATE
  );

  // Environment side.
  modport slave (
    output LOCKED_IN, SOFT_RST,
    input  MMCM_RST, RST_N_OUT, READY, FAIL, LOCK_LOSS_CNT, RETRY_CNT, STATE
  );
endinterface

// File: rtl/clkmgr_sync2.sv
// Two-flop synchroniser, async active-low reset to 0.
module clkmgr_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Metastability filter: meta then q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clkmgr_rst_seq.sv
// MMCM lock supervisor with staggered per-domain reset release and retry handling.
module clkmgr_rst_seq
  import clkmgr_pkg::*;
#(
  parameter int unsigned NUM_CHAN        = DEF_NUM_CHAN,
  parameter int unsigned STAGE_DELAY     = DEF_STAGE_DELAY,
  parameter int unsigned LOCK_STABLE     = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  clkmgr_rst_seq_if.master bus
);
  localparam int unsigned MW = cnt_w(MMCM_RST_CYCLES);
  localparam int unsigned TW = cnt_w(LOCK_TIMEOUT);
  localparam int unsigned SW = cnt_w(LOCK_STABLE);
  localparam int unsigned DW = cnt_w(STAGE_DELAY);
  localparam int unsigned IW = cnt_w(NUM_CHAN);

  state_e               state_q, state_d;
  logic [MW-1:0]        mcnt_q, mcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 mmcm_q, mmcm_d;
  logic [NUM_CHAN-1:0]  rst_q, rst_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;
  logic [CNT_WIDTH-1:0] loss_q, loss_d;
  logic [CNT_WIDTH-1:0] retry_q, retry_d;

  logic                 lk_s;
  logic                 timeout;
  logic                 go_mrst, start_rel, do_timeout, lock_loss;
  logic [CNT_WIDTH-1:0] retry_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  clkmgr_sync2 u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (bus.LOCKED_IN),
    .q     (lk_s)
  );

  assign timeout   = (tcnt_q == TW'(LOCK_TIMEOUT - 1));
  assign retry_inc = sat_inc(retry_q);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    tcnt_d     = tcnt_q;
    scnt_d     = scnt_q;
    dcnt_d     = dcnt_q;
    idx_d      = idx_q;
    mmcm_d     = mmcm_q;
    rst_d      = rst_q;
    ready_d    = ready_q;
    fail_d     = fail_q;
    loss_d     = loss_q;
    retry_d    = retry_q;
    go_mrst    = 1'b0;
    start_rel  = 1'b0;
    do_timeout = 1'b0;
    lock_loss  = 1'b0;

    if (bus.SOFT_RST) begin
      go_mrst = 1'b1;
      fail_d  = 1'b0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_MRST: begin
          if (mcnt_q == MW'(MMCM_RST_CYCLES - 1)) begin
            mmcm_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            mcnt_d = mcnt_q + MW'(1);
          end
        end
        S_WAIT: begin
          // Hold at terminal value so a lock won on the timeout cycle cannot wrap.
          tcnt_d = timeout ? tcnt_q : tcnt_q + TW'(1);
          if (lk_s) begin
            scnt_d = '0;
            if (LOCK_STABLE == 1) start_rel = 1'b1;
            else                  state_d   = S_STABLE;
          end else if (timeout) begin
            do_timeout = 1'b1;
          end
        end
        S_STABLE: begin
          tcnt_d = timeout ? tcnt_q : tcnt_q + TW'(1);
          if (lk_s && (scnt_q == SW'(LOCK_STABLE - 2))) start_rel  = 1'b1;
          else if (timeout)                             do_timeout = 1'b1;
          else if (!lk_s)                               state_d    = S_WAIT;
          else                                          scnt_d     = scnt_q + SW'(1);
        end
        S_RELEASE: begin
          if (!lk_s) begin
            lock_loss = 1'b1;
          end else if (dcnt_q == DW'(STAGE_DELAY - 1)) begin
            dcnt_d       = '0;
            rst_d[idx_q] = 1'b1;
            idx_d        = idx_q + IW'(1);
            if (idx_q == IW'(NUM_CHAN - 1)) begin
              ready_d = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        S_RUN:   if (!lk_s) lock_loss = 1'b1;
        S_FAIL:  ;
        default: go_mrst = 1'b1;
      endcase
    end

    if (start_rel) begin
      rst_d[0] = 1'b1;
      dcnt_d   = '0;
      idx_d    = IW'(1);
      if (NUM_CHAN == 1) begin
        ready_d = 1'b1;
        state_d = S_RUN;
      end else begin
        state_d = S_RELEASE;
      end
    end

    if (do_timeout) begin
      retry_d = retry_inc;
      if ((MAX_RETRY != 0) && (32'(retry_inc) >= MAX_RETRY)) begin
        state_d = S_FAIL;
        mmcm_d  = 1'b0;
        rst_d   = '0;
        ready_d = 1'b0;
        fail_d  = 1'b1;
      end else begin
        go_mrst = 1'b1;
      end
    end

    if (lock_loss) begin
      loss_d  = sat_inc(loss_q);
      go_mrst = 1'b1;
    end

    if (go_mrst) begin
      state_d = S_MRST;
      mmcm_d  = 1'b1;
      mcnt_d  = '0;
      tcnt_d  = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_MRST;
      mcnt_q  <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      dcnt_q  <= '0;
      idx_q   <= '0;
      mmcm_q  <= 1'b1;
      rst_q   <= '0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
      loss_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      dcnt_q  <= dcnt_d;
      idx_q   <= idx_d;
      mmcm_q  <= mmcm_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
      loss_q  <= loss_d;
      retry_q <= retry_d;
    end
  end

  assign bus.MMCM_RST      = mmcm_q;
  assign bus.RST_N_OUT     = rst_q;
  assign bus.READY         = ready_q;
  assign bus.FAIL          = fail_q;
  assign bus.LOCK_LOSS_CNT = loss_q;
  assign bus.RETRY_CNT     = retry_q;
  assign bus.STATE         = state_q;

endmodule

// File: tb/tb_clkmgr_rst_seq.sv
// Directed bench for the lock supervisor / staged reset sequencer.
module tb_clkmgr_rst_seq;

  logic CLK;
  logic RESET_N;
  int   n_checks;
  int   n_errors;
  int   cur;

  clkmgr_rst_seq_if #(.NUM_CHAN(4), .CNT_WIDTH(8)) bus ();

  clkmgr_rst_seq #(
    .NUM_CHAN        (4),
    .STAGE_DELAY     (4),
    .LOCK_STABLE     (8),
    .LOCK_TIMEOUT    (100),
    .MMCM_RST_CYCLES (8),
    .MAX_RETRY       (3),
    .CNT_WIDTH       (8)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cur);
    end
  endtask

  // Advance to edge e (relative to the current origin) and settle 1 time unit after it.
  task automatic go(input int e);
    while (cur < e) begin
      @(posedge CLK);
      cur++;
    end
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_mmcm"},  32'(bus.MMCM_RST), 32'd1);
    check_val({tag, "_rstn"},  32'(bus.RST_N_OUT), 32'h0);
    check_val({tag, "_ready"}, 32'(bus.READY), 32'd0);
    check_val({tag, "_fail"},  32'(bus.FAIL), 32'd0);
    check_val({tag, "_loss"},  32'(bus.LOCK_LOSS_CNT), 32'd0);
    check_val({tag, "_retry"}, 32'(bus.RETRY_CNT), 32'd0);
    check_val({tag, "_state"}, 32'(bus.STATE), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cur           = 0;
    RESET_N       = 1'b0;
    bus.LOCKED_IN = 1'b0;
    bus.SOFT_RST  = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("por");

    // Normal bring-up: reset released just after edge 0.
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    cur = 0;
    go(7);  check_val("up_mmcm7", 32'(bus.MMCM_RST), 32'd1);
    go(8);  check_val("up_mmcm8", 32'(bus.MMCM_RST), 32'd0);
            check_val("up_wait", 32'(bus.STATE), 32'd1);
    go(10); bus.LOCKED_IN = 1'b1;
    go(12); check_val("up_st12", 32'(bus.STATE), 32'd1);
    go(13); check_val("up_stable", 32'(bus.STATE), 32'd2);
    go(19); check_val("up_rst19", 32'(bus.RST_N_OUT), 32'h0);
    go(20); check_val("up_rst20", 32'(bus.RST_N_OUT), 32'h1);
            check_val("up_release", 32'(bus.STATE), 32'd3);
    go(23); check_val("up_rst23", 32'(bus.RST_N_OUT), 32'h1);
    go(24); check_val("up_rst24", 32'(bus.RST_N_OUT), 32'h3);
    go(28); check_val("up_rst28", 32'(bus.RST_N_OUT), 32'h7);
    go(31); check_val("up_rdy31", 32'(bus.READY), 32'd0);
    go(32); check_val("up_rst32", 32'(bus.RST_N_OUT), 32'hf);
            check_val("up_rdy32", 32'(bus.READY), 32'd1);
            check_val("up_run", 32'(bus.STATE), 32'd4);

    // One-cycle lock drop in RUN.
    go(40); bus.LOCKED_IN = 1'b0;
    go(41); bus.LOCKED_IN = 1'b1;
    go(42); check_val("ll_rdy42", 32'(bus.READY), 32'd1);
    go(43); check_val("ll_rst", 32'(bus.RST_N_OUT), 32'h0);
            check_val("ll_rdy", 32'(bus.READY), 32'd0);
            check_val("ll_cnt", 32'(bus.LOCK_LOSS_CNT), 32'd1);
            check_val("ll_mmcm", 32'(bus.MMCM_RST), 32'd1);
            check_val("ll_state", 32'(bus.STATE), 32'd0);
            check_val("ll_retry", 32'(bus.RETRY_CNT), 32'd0);
    go(50); check_val("ll_mmcm50", 32'(bus.MMCM_RST), 32'd1);
    go(51); check_val("ll_mmcm51", 32'(bus.MMCM_RST), 32'd0);
    go(52); check_val("ll_stable", 32'(bus.STATE), 32'd2);
    go(59); check_val("ll_rst59", 32'(bus.RST_N_OUT), 32'h1);
    go(70); check_val("ll_rdy70", 32'(bus.READY), 32'd0);
    go(71); check_val("ll_rst71", 32'(bus.RST_N_OUT), 32'hf);
            check_val("ll_rdy71", 32'(bus.READY), 32'd1);

    // SOFT_RST from RUN, then a glitchy lock.
    go(75); bus.SOFT_RST = 1'b1; bus.LOCKED_IN = 1'b0;
    go(76); bus.SOFT_RST = 1'b0;
            check_val("sr_state", 32'(bus.STATE), 32'd0);
            check_val("sr_mmcm", 32'(bus.MMCM_RST), 32'd1);
            check_val("sr_rdy", 32'(bus.READY), 32'd0);
            check_val("sr_rst", 32'(bus.RST_N_OUT), 32'h0);
            check_val("sr_loss", 32'(bus.LOCK_LOSS_CNT), 32'd1);
    cur = 0;
    go(8);  check_val("gl_wait", 32'(bus.STATE), 32'd1);
    go(10); bus.LOCKED_IN = 1'b1;
    go(13); check_val("gl_stable", 32'(bus.STATE), 32'd2);
    go(15); bus.LOCKED_IN = 1'b0;
    go(17); check_val("gl_st17", 32'(bus.STATE), 32'd2);
    go(18); check_val("gl_back", 32'(bus.STATE), 32'd1);
            check_val("gl_rst18", 32'(bus.RST_N_OUT), 32'h0);
    go(20); bus.LOCKED_IN = 1'b1;
    go(22); check_val("gl_st22", 32'(bus.STATE), 32'd1);
    go(23); check_val("gl_st23", 32'(bus.STATE), 32'd2);
    go(30); check_val("gl_rst30", 32'(bus.RST_N_OUT), 32'h1);
    go(42); check_val("gl_rst42", 32'(bus.RST_N_OUT), 32'hf);
            check_val("gl_rdy42", 32'(bus.READY), 32'd1);

    // SOFT_RST on the same cycle lock loss is seen: no lock-loss count.
    go(45); bus.LOCKED_IN = 1'b0;
    go(47); bus.SOFT_RST = 1'b1;
    go(48); bus.SOFT_RST = 1'b0;
            check_val("sl_state", 32'(bus.STATE), 32'd0);
            check_val("sl_loss", 32'(bus.LOCK_LOSS_CNT), 32'd1);
            check_val("sl_rdy", 32'(bus.READY), 32'd0);
    cur = 0;

    // Lock stuck low: timeouts every 108 cycles, FAIL on the third.
    go(107); check_val("to_r107", 32'(bus.RETRY_CNT), 32'd0);
             check_val("to_s107", 32'(bus.STATE), 32'd1);
    go(108); check_val("to_r108", 32'(bus.RETRY_CNT), 32'd1);
             check_val("to_s108", 32'(bus.STATE), 32'd0);
             check_val("to_m108", 32'(bus.MMCM_RST), 32'd1);
    go(215); check_val("to_r215", 32'(bus.RETRY_CNT), 32'd1);
    go(216); check_val("to_r216", 32'(bus.RETRY_CNT), 32'd2);
             check_val("to_s216", 32'(bus.STATE), 32'd0);
    go(323); check_val("to_s323", 32'(bus.STATE), 32'd1);
             check_val("to_f323", 32'(bus.FAIL), 32'd0);
    go(324); check_val("to_r324", 32'(bus.RETRY_CNT), 32'd3);
             check_val("to_s324", 32'(bus.STATE), 32'd5);
             check_val("to_f324", 32'(bus.FAIL), 32'd1);
             check_val("to_m324", 32'(bus.MMCM_RST), 32'd0);
             check_val("to_rst324", 32'(bus.RST_N_OUT), 32'h0);
    go(1324); check_val("to_hold_s", 32'(bus.STATE), 32'd5);
              check_val("to_hold_f", 32'(bus.FAIL), 32'd1);
              check_val("to_hold_r", 32'(bus.RETRY_CNT), 32'd3);

    // SOFT_RST out of FAIL with lock present.
    bus.LOCKED_IN = 1'b1;
    bus.SOFT_RST  = 1'b1;
    go(1325); bus.SOFT_RST = 1'b0;
              check_val("sf_state", 32'(bus.STATE), 32'd0);
              check_val("sf_fail", 32'(bus.FAIL), 32'd0);
              check_val("sf_retry", 32'(bus.RETRY_CNT), 32'd0);
              check_val("sf_mmcm", 32'(bus.MMCM_RST), 32'd1);
              check_val("sf_loss", 32'(bus.LOCK_LOSS_CNT), 32'd1);
    cur = 0;
    go(8);  check_val("sf_wait", 32'(bus.STATE), 32'd1);
    go(9);  check_val("sf_stable", 32'(bus.STATE), 32'd2);
    go(16); check_val("sf_rst16", 32'(bus.RST_N_OUT), 32'h1);
            check_val("sf_rel", 32'(bus.STATE), 32'd3);
    go(20); check_val("sf_rst20", 32'(bus.RST_N_OUT), 32'h3);

    // Async reset between bit1 and bit2 release, no clock edge needed.
    go(22);
    #2 RESET_N = 1'b0;
    #1 check_reset_vals("ar");
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    cur = 0;
    go(8);  check_val("ar_mmcm8", 32'(bus.MMCM_RST), 32'd0);
    go(9);  check_val("ar_stable", 32'(bus.STATE), 32'd2);
    go(16); check_val("ar_rst16", 32'(bus.RST_N_OUT), 32'h1);
    go(28); check_val("ar_rst28", 32'(bus.RST_N_OUT), 32'hf);
            check_val("ar_rdy28", 32'(bus.READY), 32'd1);
            check_val("ar_run", 32'(bus.STATE), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
